id_hazard_ctrl: RTL and testbench

- Issue controller for the ID stage of the pipelined RISC-V core.
- Keeps a one-bit-per-register pending-write scoreboard and decides each cycle whether the instruction in IF/ID may issue into ID/EX.
- When it may not, it stalls IF/ID and inserts a bubble into ID/EX.
- Sequences control hazards: after a branch/JAL issues, holds further issue until EX resolves it, then flushes IF/ID if taken.

---
 rtl/id_hazard_ctrl_pkg.sv | 23 ++
 rtl/id_hazard_ctrl_reg_use.sv | 69 ++++++
 rtl/id_hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_id_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage issue logic: opcodes, FSM states, register index.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rv_pkg;

  // Major opcodes (instruction[6:0]) recognised by the ID stage.
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Issue FSM: RUN issues normally; BR_WAIT holds issue until EX resolves a branch/JAL.
  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } br_state_e;

  typedef logic [4:0] reg_idx_t;

endpackage

// File: rtl/id_hazard_ctrl_reg_use.sv
// Opcode decode into register usage (rs1/rs2 read, rd write) and branch/illegal flags.
// Latency: purely combinational, same cycle.
// Backpressure: none; the caller qualifies the outputs with its valid.
//
// Ports:
//   opcode    in  7  instruction[6:0]
//   rd        in  5  instruction[11:7]
//   uses_rs1  out 1  instruction reads rs1
//   uses_rs2  out 1  instruction reads rs2
//   writes_rd out 1  instruction writes rd (never for x0)
//   is_branch out 1  conditional branch or JAL
//   illegal   out 1  opcode not supported
module id_reg_use
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_branch,
  output logic       illegal
);

  logic wr_raw;

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    wr_raw    = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        wr_raw   = 1'b1;
      end
      OP_IMM, OP_LOAD: begin
        uses_rs1 = 1'b1;
        wr_raw   = 1'b1;
      end
      OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        is_branch = 1'b1;
      end
      OP_LUI: begin
        wr_raw = 1'b1;
      end
      OP_JAL: begin
        wr_raw    = 1'b1;
        is_branch = 1'b1;
      end
      default: begin
        // Unknown opcodes travel down the pipe as a NOP: no reads, no write.
        illegal = 1'b1;
      end
    endcase
  end

  // x0 is hardwired zero, so a write to it never needs tracking.
  assign writes_rd = wr_raw & (rd != 5'd0);

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage issue control: pending-write scoreboard, RAW/WAW stall, branch hold and flush.
// Latency: issue/stall/bubble/flush are combinational; scoreboard and FSM update at the clock edge.
// Backpressure: a blocked instruction holds IF/ID (stall_if_id) while ID/EX receives a bubble.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   instr_valid, instruction     IF/ID contents
//   wb_regWrite, wb_writeReg     register-file write happening in WB this cycle
//   br_resolve_valid, br_taken   EX resolution of the outstanding branch/JAL
//   issue, stall_if_id, bubble_id_ex, flush_if_id, illegal_instr   per-cycle controls
//   br_error                     sticky branch-protocol error (timeout or stray resolve)
//   stall_count                  saturating count of stall cycles
//   pending                      scoreboard, one bit per architectural register
module id_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int WB_BYPASS  = 0,
  parameter int BR_TIMEOUT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             instr_valid,
  input  logic [31:0]      instruction,
  input  logic             wb_regWrite,
  input  logic [4:0]       wb_writeReg,
  input  logic             br_resolve_valid,
  input  logic             br_taken,
  output logic             issue,
  output logic             stall_if_id,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             illegal_instr,
  output logic             br_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [31:0]      pending
);

  // Counter only has to reach BR_TIMEOUT-1.
  localparam int TO_W = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(BR_TIMEOUT - 1);

  br_state_e       state;
  logic [TO_W-1:0] to_cnt;

  reg_idx_t rs1, rs2, rd;
  logic     uses_rs1, uses_rs2, writes_rd, is_branch, dec_illegal;
  logic     hazard;
  logic [31:0] eff_pending;
  logic [31:0] pending_nxt;

  // Immediate/funct fields are irrelevant to hazard control.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31:25], instruction[14:12]};

  assign rd  = instruction[11:7];
  assign rs1 = instruction[19:15];
  assign rs2 = instruction[24:20];

  id_reg_use u_reg_use (
    .opcode    (instruction[6:0]),
    .rd        (rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_branch (is_branch),
    .illegal   (dec_illegal)
  );

  // With bypass the register file forwards the WB value, so that register is
  // already safe to read in the WB cycle.
  always_comb begin
    eff_pending = pending;
    if ((WB_BYPASS != 0) && wb_regWrite) begin
      eff_pending[wb_writeReg] = 1'b0;
    end
  end

  // The rd term (WAW) keeps at most one outstanding write per register, so a
  // single scoreboard bit is enough.
  assign hazard = (uses_rs1  & eff_pending[rs1]) |
                  (uses_rs2  & eff_pending[rs2]) |
                  (writes_rd & eff_pending[rd]);

  assign issue         = ~reset & instr_valid & (state == ST_RUN) & ~hazard;
  assign flush_if_id   = ~reset & (state == ST_BR_WAIT) & br_resolve_valid & br_taken;
  // A flushed slot is being squashed, so there is nothing to hold.
  assign stall_if_id   = ~reset & instr_valid & ~issue & ~flush_if_id;
  assign bubble_id_ex  = ~reset & ~issue;
  assign illegal_instr = ~reset & instr_valid & dec_illegal;

  // Clear for the retiring write first, then set for the issuing one, so a
  // same-register collision leaves the new write pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_regWrite) begin
      pending_nxt[wb_writeReg] = 1'b0;
    end
    if (issue && writes_rd) begin
      pending_nxt[rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending     <= '0;
      state       <= ST_RUN;
      to_cnt      <= '0;
      stall_count <= '0;
      br_error    <= 1'b0;
    end else begin
      pending <= pending_nxt;

      if (stall_if_id && !(&stall_count)) begin
        stall_count <= stall_count + 1'b1;
      end

      case (state)
        ST_RUN: begin
          // No branch outstanding, so any resolve is a protocol violation.
          if (br_resolve_valid) begin
            br_error <= 1'b1;
          end
          if (issue && is_branch) begin
            state  <= ST_BR_WAIT;
            to_cnt <= '0;
          end
        end
        ST_BR_WAIT: begin
          if (br_resolve_valid) begin
            state <= ST_RUN;
          end else if (to_cnt == TO_LAST) begin
            br_error <= 1'b1;
            state    <= ST_RUN;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: two instances (no bypass / bypass) share stimulus.
// Latency: outputs checked mid-cycle, state checked after the following edge.
// Backpressure: stalls observed directly on stall_if_id / bubble_id_ex.
module tb_id_hazard_ctrl;

  localparam logic [31:0] ADDI_X1  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD_X2   = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] NOP_X0   = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] ADD_X0   = 32'h00000033; // add  x0,x0,x0
  localparam logic [31:0] ILLEGAL  = 32'h0000007F;
  localparam logic [31:0] LW_X3    = 32'h00002183; // lw   x3,0(x0)
  localparam logic [31:0] ADDI_X3  = 32'h00100193; // addi x3,x0,1
  localparam logic [31:0] BEQ      = 32'h00208463; // beq  x1,x2,8

  logic        clock;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instruction;
  logic        wb_regWrite;
  logic [4:0]  wb_writeReg;
  logic        br_resolve_valid;
  logic        br_taken;

  logic        issue0, stall0, bubble0, flush0, ill0, brerr0;
  logic [31:0] scnt0, pend0;
  logic        issue1, stall1, bubble1, flush1, ill1, brerr1;
  logic [31:0] scnt1, pend1;

  int n_vec = 0;
  int n_err = 0;

  id_hazard_ctrl #(.WB_BYPASS(0), .BR_TIMEOUT(4), .CNT_W(32)) u_dut0 (
    .clock            (clock),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instruction      (instruction),
    .wb_regWrite      (wb_regWrite),
    .wb_writeReg      (wb_writeReg),
    .br_resolve_valid (br_resolve_valid),
    .br_taken         (br_taken),
    .issue            (issue0),
    .stall_if_id      (stall0),
    .bubble_id_ex     (bubble0),
    .flush_if_id      (flush0),
    .illegal_instr    (ill0),
    .br_error         (brerr0),
    .stall_count      (scnt0),
    .pending          (pend0)
  );

  id_hazard_ctrl #(.WB_BYPASS(1), .BR_TIMEOUT(4), .CNT_W(32)) u_dut1 (
    .clock            (clock),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instruction      (instruction),
    .wb_regWrite      (wb_regWrite),
    .wb_writeReg      (wb_writeReg),
    .br_resolve_valid (br_resolve_valid),
    .br_taken         (br_taken),
    .issue            (issue1),
    .stall_if_id      (stall1),
    .bubble_id_ex     (bubble1),
    .flush_if_id      (flush1),
    .illegal_instr    (ill1),
    .br_error         (brerr1),
    .stall_count      (scnt1),
    .pending          (pend1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Mid-cycle sample point, well away from both clock edges.
  task automatic settle();
    #3;
  endtask

  task automatic do_reset();
    reset            = 1'b1;
    instr_valid      = 1'b0;
    instruction      = 32'h0;
    wb_regWrite      = 1'b0;
    wb_writeReg      = 5'd0;
    br_resolve_valid = 1'b0;
    br_taken         = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // ---------------- reset with live inputs ----------------
    reset            = 1'b1;
    instr_valid      = 1'b1;
    instruction      = ADD_X2;
    wb_regWrite      = 1'b1;
    wb_writeReg      = 5'd1;
    br_resolve_valid = 1'b1;
    br_taken         = 1'b1;
    tick();
    tick();
    settle();
    check_vec("rst_issue",   {31'b0, issue0},  32'd0);
    check_vec("rst_stall",   {31'b0, stall0},  32'd0);
    check_vec("rst_bubble",  {31'b0, bubble0}, 32'd0);
    check_vec("rst_flush",   {31'b0, flush0},  32'd0);
    check_vec("rst_illegal", {31'b0, ill0},    32'd0);
    check_vec("rst_brerr",   {31'b0, brerr0},  32'd0);
    check_vec("rst_scnt",    scnt0,            32'd0);
    check_vec("rst_pend",    pend0,            32'd0);
    check_vec("rst_pend1",   pend1,            32'd0);
    reset            = 1'b0;
    wb_regWrite      = 1'b0;
    wb_writeReg      = 5'd0;
    br_resolve_valid = 1'b0;
    br_taken         = 1'b0;

    // ---------------- RAW hazard ----------------
    instruction = ADDI_X1;
    settle();
    check_vec("raw_addi_issue", {31'b0, issue0}, 32'd1);
    check_vec("raw_addi_stall", {31'b0, stall0}, 32'd0);
    check_vec("post_rst_brerr", {31'b0, brerr0}, 32'd0);
    tick();
    check_vec("raw_pend_x1", pend0, 32'h2);

    instruction = ADD_X2;
    for (int i = 0; i < 2; i++) begin
      settle();
      check_vec("raw_stall",  {31'b0, stall0},  32'd1);
      check_vec("raw_bubble", {31'b0, bubble0}, 32'd1);
      check_vec("raw_stall1", {31'b0, stall1},  32'd1);
      tick();
    end
    wb_regWrite = 1'b1;
    wb_writeReg = 5'd1;
    settle();
    check_vec("raw_wb_nobyp_issue", {31'b0, issue0}, 32'd0);
    check_vec("raw_wb_byp_issue",   {31'b0, issue1}, 32'd1);
    check_vec("raw_wb_byp_stall",   {31'b0, stall1}, 32'd0);
    tick();
    wb_regWrite = 1'b0;
    settle();
    check_vec("raw_after_wb_issue", {31'b0, issue0}, 32'd1);
    check_vec("raw_scnt0",          scnt0,           32'd3);
    check_vec("raw_scnt1",          scnt1,           32'd2);
    check_vec("raw_pend1_x2",       pend1,           32'h4);
    tick();
    check_vec("raw_pend0_x2", pend0, 32'h4);

    // ---------------- x0 writes and illegal opcode ----------------
    do_reset();
    instr_valid = 1'b1;
    instruction = NOP_X0;
    settle();
    check_vec("x0_nop_issue", {31'b0, issue0}, 32'd1);
    tick();
    instruction = ADD_X0;
    settle();
    check_vec("x0_add_issue", {31'b0, issue0}, 32'd1);
    check_vec("x0_add_stall", {31'b0, stall0}, 32'd0);
    tick();
    check_vec("x0_pend", pend0, 32'd0);
    instruction = ILLEGAL;
    settle();
    check_vec("ill_flag",   {31'b0, ill0},    32'd1);
    check_vec("ill_issue",  {31'b0, issue0},  32'd1);
    check_vec("ill_bubble", {31'b0, bubble0}, 32'd0);
    tick();
    check_vec("ill_pend", pend0, 32'd0);

    // ---------------- WAW and same-cycle set/clear ----------------
    instruction = LW_X3;
    settle();
    check_vec("waw_lw_issue", {31'b0, issue0}, 32'd1);
    tick();
    check_vec("waw_pend_x3", pend1, 32'h8);
    wb_regWrite = 1'b1;
    wb_writeReg = 5'd3;
    settle();
    check_vec("waw_nobyp_stall", {31'b0, stall0}, 32'd1);
    check_vec("waw_byp_issue",   {31'b0, issue1}, 32'd1);
    tick();
    check_vec("waw_setwins_pend1", pend1, 32'h8);
    check_vec("waw_cleared_pend0", pend0, 32'h0);
    wb_regWrite = 1'b0;
    instruction = ADDI_X3;
    settle();
    check_vec("waw_second_stall1", {31'b0, stall1}, 32'd1);
    check_vec("waw_second_issue0", {31'b0, issue0}, 32'd1);
    tick();

    // ---------------- branch taken ----------------
    do_reset();
    instr_valid = 1'b1;
    instruction = BEQ;
    settle();
    check_vec("bt_beq_issue", {31'b0, issue0}, 32'd1);
    tick();
    instruction = ADDI_X1;
    settle();
    check_vec("bt_wait_issue", {31'b0, issue0}, 32'd0);
    check_vec("bt_wait_stall", {31'b0, stall0}, 32'd1);
    check_vec("bt_wait_flush", {31'b0, flush0}, 32'd0);
    tick();
    br_resolve_valid = 1'b1;
    br_taken         = 1'b1;
    settle();
    check_vec("bt_flush",  {31'b0, flush0},  32'd1);
    check_vec("bt_fstall", {31'b0, stall0},  32'd0);
    check_vec("bt_fbub",   {31'b0, bubble0}, 32'd1);
    tick();
    br_resolve_valid = 1'b0;
    br_taken         = 1'b0;
    settle();
    check_vec("bt_flush_once", {31'b0, flush0}, 32'd0);
    check_vec("bt_run_issue",  {31'b0, issue0}, 32'd1);
    check_vec("bt_brerr",      {31'b0, brerr0}, 32'd0);
    tick();

    // ---------------- branch not taken ----------------
    do_reset();
    instr_valid = 1'b1;
    instruction = BEQ;
    tick();
    instruction = ADDI_X1;
    settle();
    check_vec("bn_wait_stall", {31'b0, stall0}, 32'd1);
    tick();
    br_resolve_valid = 1'b1;
    br_taken         = 1'b0;
    settle();
    check_vec("bn_noflush", {31'b0, flush0}, 32'd0);
    check_vec("bn_stall",   {31'b0, stall0}, 32'd1);
    check_vec("bn_issue",   {31'b0, issue0}, 32'd0);
    tick();
    br_resolve_valid = 1'b0;
    settle();
    check_vec("bn_next_issue", {31'b0, issue0}, 32'd1);
    tick();

    // ---------------- timeout ----------------
    do_reset();
    instr_valid = 1'b1;
    instruction = BEQ;
    tick();
    instruction = ADDI_X1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_vec("to_wait_issue", {31'b0, issue0}, 32'd0);
      check_vec("to_wait_brerr", {31'b0, brerr0}, 32'd0);
      tick();
    end
    settle();
    check_vec("to_brerr",     {31'b0, brerr0}, 32'd1);
    check_vec("to_run_issue", {31'b0, issue0}, 32'd1);
    check_vec("to_noflush",   {31'b0, flush0}, 32'd0);
    tick();

    // ---------------- stray resolve in RUN ----------------
    do_reset();
    settle();
    check_vec("stray_pre_brerr", {31'b0, brerr0}, 32'd0);
    br_resolve_valid = 1'b1;
    br_taken         = 1'b1;
    settle();
    check_vec("stray_noflush", {31'b0, flush0}, 32'd0);
    tick();
    br_resolve_valid = 1'b0;
    br_taken         = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check_vec("stray_sticky", {31'b0, brerr0}, 32'd1);
    do_reset();
    settle();
    check_vec("stray_cleared", {31'b0, brerr0}, 32'd0);

    // ---------------- reset abandons an outstanding branch ----------------
    instr_valid = 1'b1;
    instruction = BEQ;
    tick();
    do_reset();
    br_resolve_valid = 1'b1;
    settle();
    check_vec("abandon_noflush", {31'b0, flush0}, 32'd0);
    tick();
    br_resolve_valid = 1'b0;
    settle();
    check_vec("abandon_brerr", {31'b0, brerr0}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
